// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Produces 640x480 @ 60 Hz VGA raster timing from the system clock and drives
// the VGA connector pins. The raster position (pixel_x/pixel_y) goes to the
// render engine. The engine's colour (rgb_in) is captured one pixel later.
// Sync and blanking are delayed by the same pixel, so colour and sync stay
// aligned at the connector. A one-clock vblank_start pulse tells game logic
// that the visible area has just ended.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-low
//   rgb_in        in   12-bit colour for the current pixel_x/pixel_y
//   pixel_tick    out  one-clk pulse per pixel period
//   pixel_x       out  horizontal position, 0..H_TOTAL-1
//   pixel_y       out  vertical position, 0..V_TOTAL-1
//   video_on      out  current position is visible (undelayed)
//   vblank_start  out  one-clk pulse when pixel_y enters V_VISIBLE
//   vga_hsync     out  horizontal sync pin, active-low, one pixel behind
//   vga_vsync     out  vertical sync pin, active-low, one pixel behind
//   vga_rgb       out  colour pin, one pixel behind, zero while blanked
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic        pixel_tick,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        vblank_start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sized decode constants keep every comparison at the counter width.
  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Divider and raster state (stage 0: position presented to the renderer)
  logic [3:0]  div_cnt_q, div_cnt_d;
  logic        tick_q, tick_d;
  logic [9:0]  x_p0_q, x_p0_d;
  logic [9:0]  y_p0_q, y_p0_d;

  // Pin stage (stage 1: one pixel behind the raster position)
  logic        hs_p1_q, hs_p1_d;
  logic        vs_p1_q, vs_p1_d;
  logic [11:0] rgb_p1_q, rgb_p1_d;
  logic        vblank_q, vblank_d;

  logic        hs_int;
  logic        vs_int;
  logic        vid_p0;

  // Undelayed decode of the current raster position
  always_comb begin
    vid_p0 = (x_p0_q < H_VIS) && (y_p0_q < V_VIS);
    hs_int = !((x_p0_q >= HS_START) && (x_p0_q < HS_END));
    vs_int = !((y_p0_q >= VS_START) && (y_p0_q < VS_END));
  end

  // The divider free-runs. With CLK_DIV=1, DIV_LAST is 0, so the tick fires
  // on every edge after reset.
  always_comb begin
    div_cnt_d = div_cnt_q + 4'd1;
    tick_d    = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = 4'd0;
      tick_d    = 1'b1;
    end
  end

  // Raster counters and the pin stage share the registered tick as enable.
  // The pins therefore capture the decode of the position that is about to
  // be left, which is the one-pixel delay.
  always_comb begin
    x_p0_d   = x_p0_q;
    y_p0_d   = y_p0_q;
    hs_p1_d  = hs_p1_q;
    vs_p1_d  = vs_p1_q;
    rgb_p1_d = rgb_p1_q;
    vblank_d = 1'b0;
    if (tick_q) begin
      if (x_p0_q == H_LAST) begin
        x_p0_d = 10'd0;
        if (y_p0_q == V_LAST) begin
          y_p0_d = 10'd0;
        end else begin
          y_p0_d = y_p0_q + 10'd1;
        end
      end else begin
        x_p0_d = x_p0_q + 10'd1;
      end
      hs_p1_d  = hs_int;
      vs_p1_d  = vs_int;
      rgb_p1_d = vid_p0 ? rgb_in : 12'h000;
      vblank_d = (x_p0_q == H_LAST) && (y_p0_q == V_VIS_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= 4'd0;
      tick_q    <= 1'b0;
      x_p0_q    <= 10'd0;
      y_p0_q    <= 10'd0;
      hs_p1_q   <= 1'b1;
      vs_p1_q   <= 1'b1;
      rgb_p1_q  <= 12'h000;
      vblank_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      x_p0_q    <= x_p0_d;
      y_p0_q    <= y_p0_d;
      hs_p1_q   <= hs_p1_d;
      vs_p1_q   <= vs_p1_d;
      rgb_p1_q  <= rgb_p1_d;
      vblank_q  <= vblank_d;
    end
  end

  assign pixel_tick   = tick_q;
  assign pixel_x      = x_p0_q;
  assign pixel_y      = y_p0_q;
  assign video_on     = vid_p0;
  assign vblank_start = vblank_q;
  assign vga_hsync    = hs_p1_q;
  assign vga_vsync    = vs_p1_q;
  assign vga_rgb      = rgb_p1_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// Testbench for vga_timing_gen, using a reduced raster so that several frames
// fit in a short run. Expected outputs are computed in closed form from the
// number of clock edges since reset release. They are pushed to a scoreboard
// queue on each rising edge and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int D  = 4;
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 25
  localparam int VT = VV + VF + VS + VB;   // 15
  localparam int FRAME_CLKS = HT * VT * D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] rgb_in = 12'h000;
  logic        pixel_tick, video_on, vblank_start, vga_hsync, vga_vsync;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] vga_rgb;

  vga_timing_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .vblank_start(vblank_start), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vid;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        vb;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int k      = 0;    // rising edges since reset release
  int mode   = 0;    // 0: hashed colour, 1: white, 2: {2'b0, x}
  logic        e_hs  = 1'b1;
  logic        e_vs  = 1'b1;
  logic [11:0] e_rgb = 12'h000;

  function automatic int pos_x(int n);
    return n % HT;
  endfunction

  function automatic int pos_y(int n);
    return (n / HT) % VT;
  endfunction

  function automatic logic visible(int x, int y);
    return (x < HV) && (y < VV);
  endfunction

  function automatic logic [11:0] pattern(int n);
    case (mode)
      1:       return 12'hFFF;
      2:       return {2'b00, 10'(pos_x(n))};
      default: return 12'((n * 149 + 7) ^ (n >> 2));
    endcase
  endfunction

  // One clock: push the expectation for this edge, drive rgb_in for the new
  // position, then pop and compare on the falling edge.
  task automatic step_cycle();
    logic [11:0] rgb_before;
    int n, px, py;
    logic step;
    exp_t e, o;
    rgb_before = rgb_in;
    @(posedge clk);
    k++;
    n    = (k - 1) / D;
    step = (k >= D + 1) && (((k - 1) % D) == 0);
    px   = 0;
    py   = 0;
    if (step) begin
      px    = pos_x(n - 1);
      py    = pos_y(n - 1);
      e_hs  = !((px >= HV + HF) && (px < HV + HF + HS));
      e_vs  = !((py >= VV + VF) && (py < VV + VF + VS));
      e_rgb = visible(px, py) ? rgb_before : 12'h000;
    end
    e.tick = ((k % D) == 0);
    e.x    = 10'(pos_x(n));
    e.y    = 10'(pos_y(n));
    e.vid  = visible(pos_x(n), pos_y(n));
    e.hs   = e_hs;
    e.vs   = e_vs;
    e.rgb  = e_rgb;
    e.vb   = step && (px == HT - 1) && (py == VV - 1);
    sb.push_back(e);
    #1 rgb_in = pattern(n);
    @(negedge clk);
    o = sb.pop_front();
    checks++;
    if (pixel_tick !== o.tick) begin
      errors++;
      $display("FAIL tick k=%0d got=%b exp=%b", k, pixel_tick, o.tick);
    end
    checks++;
    if (pixel_x !== o.x || pixel_y !== o.y) begin
      errors++;
      $display("FAIL pos k=%0d got=(%0d,%0d) exp=(%0d,%0d)", k, pixel_x, pixel_y, o.x, o.y);
    end
    checks++;
    if (video_on !== o.vid) begin
      errors++;
      $display("FAIL video_on k=%0d got=%b exp=%b", k, video_on, o.vid);
    end
    checks++;
    if (vga_hsync !== o.hs || vga_vsync !== o.vs) begin
      errors++;
      $display("FAIL sync k=%0d got=%b%b exp=%b%b", k, vga_hsync, vga_vsync, o.hs, o.vs);
    end
    checks++;
    if (vga_rgb !== o.rgb) begin
      errors++;
      $display("FAIL rgb k=%0d got=%h exp=%h", k, vga_rgb, o.rgb);
    end
    checks++;
    if (vblank_start !== o.vb) begin
      errors++;
      $display("FAIL vblank k=%0d got=%b exp=%b", k, vblank_start, o.vb);
    end
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) step_cycle();
  endtask

  task automatic check_reset_values(string tag);
    checks++;
    if (pixel_tick !== 1'b0 || pixel_x !== 10'd0 || pixel_y !== 10'd0 ||
        vblank_start !== 1'b0 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1 ||
        vga_rgb !== 12'h000 || video_on !== 1'b1) begin
      errors++;
      $display("FAIL %s got tick=%b x=%0d y=%0d vb=%b hs=%b vs=%b rgb=%h vid=%b exp 0,0,0,0,1,1,000,1",
               tag, pixel_tick, pixel_x, pixel_y, vblank_start, vga_hsync, vga_vsync, vga_rgb, video_on);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst   = 1'b1;
    k     = 0;
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_rgb = 12'h000;
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_values("reset_hold");
    release_reset();
    first = -1;
    for (int i = 0; i < 6 * D; i++) begin
      step_cycle();
      if (first < 0 && pixel_tick === 1'b1) first = k;
    end
    checks++;
    if (first != D) begin
      errors++;
      $display("FAIL first_tick got=%0d exp=%0d", first, D);
    end
  endtask

  task automatic test_horizontal();
    int ticks, hs_low;
    mode   = 0;
    ticks  = 0;
    hs_low = 0;
    run(HT * D);
    for (int i = 0; i < HT * D; i++) begin
      step_cycle();
      if (pixel_tick === 1'b1) ticks++;
      if (vga_hsync === 1'b0) hs_low++;
    end
    checks++;
    if (ticks != HT) begin
      errors++;
      $display("FAIL line_ticks got=%0d exp=%0d", ticks, HT);
    end
    checks++;
    if (hs_low != HS * D) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=%0d", hs_low, HS * D);
    end
  endtask

  task automatic test_vertical_blanking();
    int vb_cnt, vs_low, white;
    mode   = 1;
    vb_cnt = 0;
    vs_low = 0;
    white  = 0;
    run(HT * D);
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      step_cycle();
      if (vblank_start === 1'b1) vb_cnt++;
      if (vga_vsync === 1'b0) vs_low++;
      if (vga_rgb === 12'hFFF) white++;
    end
    checks++;
    if (vb_cnt != 2) begin
      errors++;
      $display("FAIL vblank_count got=%0d exp=2", vb_cnt);
    end
    checks++;
    if (vs_low != 2 * VS * HT * D) begin
      errors++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_low, 2 * VS * HT * D);
    end
    checks++;
    if (white != 2 * VV * HV * D) begin
      errors++;
      $display("FAIL white_cycles got=%0d exp=%0d", white, 2 * VV * HV * D);
    end
  endtask

  task automatic test_alignment();
    mode = 2;
    run(3 * HT * D);
  endtask

  task automatic test_async_reset();
    int guard;
    mode  = 0;
    guard = 0;
    while (!(pixel_x == 10'd10 && pixel_y == 10'd5) && guard < 2 * FRAME_CLKS) begin
      step_cycle();
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME_CLKS) begin
      errors++;
      $display("FAIL reach_target got=(%0d,%0d) exp=(10,5)", pixel_x, pixel_y);
    end
    #1 rst = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (3) @(negedge clk);
    check_reset_values("async_hold");
    release_reset();
    run(FRAME_CLKS + HT * D);
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical_blanking();
    test_alignment();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
